// File: rtl/spi_memory_master.sv
// SPI mode-0 master issuing 16-bit {addr, rw, data} frames to a 128 x 8 SPI memory.
// Define SPI_MASTER_ABORT_EN to let the abort input cut a frame short.
module spi_memory_master #(
  parameter int CLKDIV = 25,
  parameter int CS_GAP = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic       req_rw,
  input  logic [7:0] req_wdata,
  input  logic       abort,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_abort,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int DIV_W = $clog2(CLKDIV);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, FINISH, GAP} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic [4:0]       edge_cnt, edge_n;
  logic [15:0]      tx_sr, tx_n;
  logic [7:0]       rx_sr, rx_n, rdata_n;
  logic             is_read, is_read_n;
  logic             sclk_n, cs_n, rsp_valid_n;
  logic             div_tick;

  assign div_tick  = (div_cnt == DIV_LAST);
  assign req_ready = (state == IDLE);
  // Read frames load zeros into the data byte, so mosi is low for bits 9..16.
  assign mosi_pin  = tx_sr[15];

`ifdef SPI_MASTER_ABORT_EN
  logic abort_n;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign rsp_abort    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      edge_cnt  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      is_read   <= 1'b0;
      sclk_pin  <= 1'b0;
      cs_pin    <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef SPI_MASTER_ABORT_EN
      rsp_abort <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      gap_cnt   <= gap_n;
      edge_cnt  <= edge_n;
      tx_sr     <= tx_n;
      rx_sr     <= rx_n;
      is_read   <= is_read_n;
      sclk_pin  <= sclk_n;
      cs_pin    <= cs_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rdata_n;
`ifdef SPI_MASTER_ABORT_EN
      rsp_abort <= abort_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    div_n       = div_cnt;
    gap_n       = gap_cnt;
    edge_n      = edge_cnt;
    tx_n        = tx_sr;
    rx_n        = rx_sr;
    is_read_n   = is_read;
    sclk_n      = sclk_pin;
    cs_n        = cs_pin;
    rsp_valid_n = 1'b0;
    rdata_n     = rsp_rdata;
`ifdef SPI_MASTER_ABORT_EN
    abort_n     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          tx_n      = {req_addr, req_rw, req_rw ? 8'h00 : req_wdata};
          is_read_n = req_rw;
          cs_n      = 1'b0;
          div_n     = '0;
          state_n   = SETUP;
        end
      end
      SETUP: begin
        div_n = div_tick ? '0 : div_cnt + DIV_W'(1);
        if (div_tick) begin
          sclk_n  = 1'b1;
          edge_n  = 5'd1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        div_n = div_tick ? '0 : div_cnt + DIV_W'(1);
        if (div_tick) begin
          if (sclk_pin) begin
            // Falling edge: capture data bits, then present the next mosi bit.
            sclk_n = 1'b0;
            if (edge_cnt >= 5'd9) rx_n = {rx_sr[6:0], miso_pin};
            if (edge_cnt == 5'd16) begin
              tx_n    = '0;
              state_n = FINISH;
            end else begin
              tx_n = {tx_sr[14:0], 1'b0};
            end
          end else begin
            sclk_n = 1'b1;
            edge_n = edge_cnt + 5'd1;
          end
        end
      end
      FINISH: begin
        div_n = div_tick ? '0 : div_cnt + DIV_W'(1);
        if (div_tick) begin
          cs_n        = 1'b1;
          rsp_valid_n = 1'b1;
          if (is_read) rdata_n = rx_sr;
          gap_n       = '0;
          state_n     = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = IDLE;
        else gap_n = gap_cnt + GAP_W'(1);
      end
      default: state_n = IDLE;
    endcase
`ifdef SPI_MASTER_ABORT_EN
    if (abort && (state == SETUP || state == SHIFT || state == FINISH)) begin
      sclk_n      = 1'b0;
      cs_n        = 1'b1;
      tx_n        = '0;
      rsp_valid_n = 1'b1;
      abort_n     = 1'b1;
      rdata_n     = rsp_rdata;
      gap_n       = '0;
      state_n     = GAP;
    end
`endif
  end

endmodule
